fifo_spi_tx: RTL and testbench
==============================

# fifo_spi_tx

Read-side consumer for the pixel/command FIFO: pops 9-bit words (`{dc, byte}`) from the FIFO's read port and serializes each byte onto an SPI mode-0 link to the LCD panel, MSB first, with the D/C line held for the whole byte. It sits between the FIFO and the display pins, drains the FIFO in bursts, and holds chip-select low across back-to-back bytes.

## Interface
- `DATABITS`, 9: FIFO word width; bit 8 = D/C, bits 7:0 = payload byte.
- `CLKDIV`, 2: SCK half-period in `clk` cycles; legal range 1..255.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `enable` input 1: permits starting a new byte; sampled only in IDLE and NEXT.
- `fifo_read_data` input DATABITS: FIFO head word, registered RAM output.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_read_en` output 1: one-cycle pop strobe to the FIFO.
- `spi_sck` output 1: serial clock, idle low.
- `spi_mosi` output 1: serial data.
- `spi_cs_n` output 1: chip select, active low.
- `spi_dc` output 1: data/command select, latched per byte.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- States: IDLE, LOAD, SCK_LO, SCK_HI, NEXT.
- IDLE: `spi_cs_n`=1, `spi_sck`=0. If `enable` && !`fifo_empty` -> LOAD.
- LOAD (exactly 1 cycle): `fifo_read_en`=1; shift reg <= `fifo_read_data[7:0]`; `spi_dc` <= `fifo_read_data[8]`; `spi_mosi` <= `fifo_read_data[7]`; `spi_cs_n` <= 0; bit counter <= 7; divider <= 0 -> SCK_LO.
- SCK_LO: `spi_sck`=0; after CLKDIV cycles drive `spi_sck` <= 1 -> SCK_HI.
- SCK_HI: after CLKDIV cycles drive `spi_sck` <= 0; if bit counter = 0 -> NEXT, else shift left, `spi_mosi` <= next bit, counter-1 -> SCK_LO.
- NEXT (1 cycle): if `enable` && !`fifo_empty` -> LOAD with `spi_cs_n` held low (burst continues); else `spi_cs_n` <= 1, `spi_mosi` <= 0 -> IDLE.
- Entry to LOAD from IDLE requires one IDLE cycle with `fifo_empty`=0, which covers the FIFO's one-cycle registered read latency after a write into an empty FIFO.
- Pop-to-next-pop distance is >= 2*CLKDIV*8+2 cycles, so the head word has always settled before the next LOAD.
- `enable` falling mid-byte: current byte completes in full; burst ends at NEXT.
- `fifo_read_en` is asserted only in LOAD; never when `fifo_empty`=1.

## Timing
- Reset (async, `rst`=0): state IDLE; `spi_sck`=0, `spi_mosi`=0, `spi_cs_n`=1, `spi_dc`=0, `busy`=0, `fifo_read_en`=0; counters 0. Reset mid-byte aborts immediately; the popped word is lost; CS deasserts in the same cycle.
- All SPI outputs are registered; `fifo_read_en` and `busy` are decoded from the state register.
- Mode 0: MOSI changes only on SCK falling edge or in LOAD; it is stable >= CLKDIV cycles before each SCK rise.
- Per byte: 1 (LOAD) + 16*CLKDIV + 1 (NEXT) cycles; CLKDIV=2 gives 34 cycles/byte back-to-back.
- CS low to first SCK rise: CLKDIV cycles. Last SCK fall to CS high: 1 cycle.
- Divider and bit counter are sized from CLKDIV and 3 bits respectively; no wrap beyond the terminal count.

## Structure
- Shared package: state enum (`ST_IDLE`..`ST_NEXT`), `DC_BIT` index (8), default CLKDIV.
- One sub-module is natural: `spi_half_tick`, a loadable CLKDIV down-counter producing a terminal-count pulse; the FSM, shift register and bit counter stay in `fifo_spi_tx`.

## Test plan
- Reset: hold `rst`=0 with FIFO non-empty -> `spi_cs_n`=1, `spi_sck`=0, `fifo_read_en`=0 throughout; release -> first LOAD one cycle after IDLE sees !`fifo_empty`.
- Single byte: word 9'h1A5 -> one `fifo_read_en` pulse, 8 SCK rises sampling 1,0,1,0,0,1,0,1, `spi_dc`=1, CS high 1 cycle after last fall; 34 cycles at CLKDIV=2.
- Burst: 3 words 9'h0F0, 9'h155, 9'h1FF preloaded -> CS stays low across all 24 SCK rises, `spi_dc` 0,1,1 per byte, exactly 3 pops, 102 cycles total.
- Write into empty FIFO while IDLE -> transmitted byte equals written value (no stale head), CLKDIV=1.
- `enable` dropped at bit 3 of byte 1 with 2 words queued -> byte 1 completes, CS rises, second word remains unpopped until `enable` returns.
- Async reset asserted in SCK_HI of bit 4 -> outputs return to reset values without a clock edge; next word transmits cleanly after release.

Source files
------------

// File: rtl/fifo_spi_tx_pkg.sv
// Shared types and constants for the FIFO-to-LCD SPI transmitter.
package fifo_spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_NEXT
  } state_t;

  localparam int DC_BIT     = 8;
  localparam int CLKDIV_DEF = 2;

  // Width of a down-counter that must hold CLKDIV-1.
  function automatic int div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/fifo_spi_tx_if.sv
// FIFO read port, enable/busy and LCD SPI pins of the transmitter.
interface fifo_spi_tx_if
  import fifo_spi_tx_pkg::*;
#(
  parameter int DATABITS = DC_BIT + 1
);
  logic                enable;
  logic                busy;
  logic [DATABITS-1:0] fifo_read_data;
  logic                fifo_empty;
  logic                fifo_read_en;
  logic                spi_sck;
  logic                spi_mosi;
  logic                spi_cs_n;
  logic                spi_dc;

  modport master (
    input  enable, fifo_read_data, fifo_empty,
    output busy, fifo_read_en, spi_sck, spi_mosi, spi_cs_n, spi_dc
  );

  modport slave (
    output enable, fifo_read_data, fifo_empty,
    input  busy, fifo_read_en, spi_sck, spi_mosi, spi_cs_n, spi_dc
  );
endinterface

// File: rtl/fifo_spi_tx_half_tick.sv
// Loadable CLKDIV down-counter; tc marks the last cycle of an SCK half-period.
module spi_half_tick
  import fifo_spi_tx_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tc
);
  localparam int W = div_w(CLKDIV);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (load)        cnt <= W'(CLKDIV - 1);
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/fifo_spi_tx.sv
// Drains {dc,byte} words from the FIFO and shifts them out as SPI mode 0,
// MSB first, keeping CS low across back-to-back bytes.
module fifo_spi_tx
  import fifo_spi_tx_pkg::*;
#(
  parameter int DATABITS = DC_BIT + 1,
  parameter int CLKDIV   = CLKDIV_DEF
) (
  input logic          clk,
  input logic          rst,
  fifo_spi_tx_if.master bus
);
  state_t     state;
  logic [6:0] shreg;    // bits still to send after the one on MOSI
  logic [2:0] bit_cnt;
  logic       sck_q, mosi_q, cs_n_q, dc_q;
  logic       tc, tick_load;

  // Reload at LOAD and at every half-period boundary so each phase is CLKDIV long.
  assign tick_load = (state == ST_LOAD) ||
                     (((state == ST_SCK_LO) || (state == ST_SCK_HI)) && tc);

  spi_half_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.enable && !bus.fifo_empty) state <= ST_LOAD;
        ST_LOAD: begin
          shreg   <= bus.fifo_read_data[6:0];
          dc_q    <= bus.fifo_read_data[DC_BIT];
          mosi_q  <= bus.fifo_read_data[7];
          cs_n_q  <= 1'b0;
          bit_cnt <= 3'd7;
          state   <= ST_SCK_LO;
        end
        ST_SCK_LO: if (tc) begin
          sck_q <= 1'b1;
          state <= ST_SCK_HI;
        end
        ST_SCK_HI: if (tc) begin
          sck_q <= 1'b0;
          if (bit_cnt == 3'd0) begin
            state <= ST_NEXT;
          end else begin
            mosi_q  <= shreg[6];
            shreg   <= {shreg[5:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
            state   <= ST_SCK_LO;
          end
        end
        ST_NEXT: begin
          if (bus.enable && !bus.fifo_empty) begin
            state <= ST_LOAD;
          end else begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_read_en = (state == ST_LOAD);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.spi_sck      = sck_q;
  assign bus.spi_mosi     = mosi_q;
  assign bus.spi_cs_n     = cs_n_q;
  assign bus.spi_dc       = dc_q;
endmodule

// File: tb/tb_fifo_spi_tx.sv
// Scoreboard bench: lane 0 runs CLKDIV=2, lane 1 runs CLKDIV=1, each fed by a
// behavioural FIFO with a one-cycle registered head.
module tb_fifo_spi_tx;
  import fifo_spi_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_spi_tx_if #(.DATABITS(9)) b0 ();
  fifo_spi_tx_if #(.DATABITS(9)) b1 ();

  fifo_spi_tx #(.DATABITS(9), .CLKDIV(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  fifo_spi_tx #(.DATABITS(9), .CLKDIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [1:0] en = 2'b00;
  logic [1:0] empty = 2'b11;
  logic [8:0] rdata [2];
  logic [1:0] sck, mosi, csn, dcs, ren, bsy;

  assign b0.enable = en[0];
  assign b1.enable = en[1];
  assign b0.fifo_empty = empty[0];
  assign b1.fifo_empty = empty[1];
  assign b0.fifo_read_data = rdata[0];
  assign b1.fifo_read_data = rdata[1];
  assign sck  = {b1.spi_sck,      b0.spi_sck};
  assign mosi = {b1.spi_mosi,     b0.spi_mosi};
  assign csn  = {b1.spi_cs_n,     b0.spi_cs_n};
  assign dcs  = {b1.spi_dc,       b0.spi_dc};
  assign ren  = {b1.fifo_read_en, b0.fifo_read_en};
  assign bsy  = {b1.busy,         b0.busy};

  // fmem doubles as the scoreboard: every written word must come out in order.
  logic [8:0] fmem [2][64];
  int wp[2], rp[2], seen_wp[2], xp[2];
  int pops[2], bytes[2], busy_cyc[2], cs_rises[2], bitn[2], since_fall[2];
  logic [7:0] rx [2];
  logic       dcv [2];
  logic [1:0] psck, pmosi, pcsn;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int l, input logic [8:0] w);
    fmem[l][wp[l] % 64] = w;
    wp[l]++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int l, input int budget);
    int c;
    c = 0;
    while ((wp[l] != rp[l] || bsy[l]) && c < budget) begin
      tick(1);
      c++;
    end
    if (c >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout lane %0d: got %0d cycles, required < %0d", l, c, budget);
    end
    tick(1);
  endtask

  // FIFO model and output monitor, sampled on the falling edge.
  initial begin
    logic [8:0] head;
    logic rise, fall;
    for (int l = 0; l < 2; l++) begin
      wp[l] = 0; rp[l] = 0; seen_wp[l] = 0; xp[l] = 0; pops[l] = 0; bytes[l] = 0;
      busy_cyc[l] = 0; cs_rises[l] = 0; bitn[l] = 0; since_fall[l] = 0;
      rdata[l] = '0; rx[l] = '0; dcv[l] = 1'b0;
    end
    psck = '0; pmosi = '0; pcsn = '1;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        head = (seen_wp[l] != rp[l]) ? fmem[l][rp[l] % 64] : rdata[l];
        if (ren[l]) begin
          check("pop_while_empty", {31'd0, empty[l]}, 32'd0);
          rp[l]++;
          pops[l]++;
        end
        seen_wp[l] = wp[l];
        rdata[l]   = head;
        empty[l]   = (wp[l] == rp[l]);

        if (!rst) begin
          bitn[l] = 0;
        end else begin
          rise = !psck[l] && sck[l];
          fall = psck[l] && !sck[l];
          if (fall) since_fall[l] = 0;
          else      since_fall[l]++;
          if (csn[l] && !pcsn[l]) begin
            cs_rises[l]++;
            check("cs_high_after_last_fall", since_fall[l], 1);
          end
          if (sck[l] && psck[l])
            check("mosi_stable_sck_high", {31'd0, mosi[l]}, {31'd0, pmosi[l]});
          if (rise) begin
            check("cs_low_at_rise", {31'd0, csn[l]}, 32'd0);
            if (bitn[l] == 0) dcv[l] = dcs[l];
            else check("dc_stable", {31'd0, dcs[l]}, {31'd0, dcv[l]});
            rx[l] = {rx[l][6:0], mosi[l]};
            bitn[l]++;
            if (bitn[l] == 8) begin
              bitn[l] = 0;
              bytes[l]++;
              if (xp[l] >= wp[l]) begin
                check("unexpected_byte", {23'd0, dcv[l], rx[l]}, 32'h200);
              end else begin
                check($sformatf("byte_lane%0d", l), {23'd0, dcv[l], rx[l]},
                      {23'd0, fmem[l][xp[l] % 64]});
                xp[l]++;
              end
            end
          end
          if (bsy[l]) busy_cyc[l]++;
        end
      end
      psck = sck; pmosi = mosi; pcsn = csn;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_busy, s_pops, s_bytes, s_cs, c, n;
    // Reset held with a word queued: nothing may move.
    push(0, 9'h1A5);
    en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rst_cs_n", {31'd0, csn[0]}, 1);
      check("rst_sck",  {31'd0, sck[0]}, 0);
      check("rst_read_en", {31'd0, ren[0]}, 0);
      check("rst_busy", {31'd0, bsy[0]}, 0);
    end
    s_busy = busy_cyc[0]; s_pops = pops[0]; s_bytes = bytes[0]; s_cs = cs_rises[0];
    rst = 1'b1;
    c = 0;
    while (!ren[0] && c < 20) begin tick(1); c++; end
    check("first_load_latency", c, 1);
    drain(0, 200);
    check("single_cycles", busy_cyc[0] - s_busy, 34);
    check("single_pops",   pops[0] - s_pops, 1);
    check("single_bytes",  bytes[0] - s_bytes, 1);
    check("single_cs_rise", cs_rises[0] - s_cs, 1);

    // Preloaded burst of three.
    en[0] = 1'b0;
    push(0, 9'h0F0); push(0, 9'h155); push(0, 9'h1FF);
    tick(3);
    s_busy = busy_cyc[0]; s_pops = pops[0]; s_bytes = bytes[0]; s_cs = cs_rises[0];
    en[0] = 1'b1;
    drain(0, 400);
    check("burst_cycles", busy_cyc[0] - s_busy, 102);
    check("burst_pops",   pops[0] - s_pops, 3);
    check("burst_bytes",  bytes[0] - s_bytes, 3);
    check("burst_cs_rise", cs_rises[0] - s_cs, 1);

    // CLKDIV=1: write into an empty FIFO while idle must not send the stale head.
    en[1] = 1'b1;
    push(1, 9'h0AA);
    drain(1, 100);
    s_busy = busy_cyc[1]; s_bytes = bytes[1];
    push(1, 9'h133);
    drain(1, 100);
    check("div1_cycles", busy_cyc[1] - s_busy, 18);
    check("div1_bytes",  bytes[1] - s_bytes, 1);

    // Enable dropped mid-byte: the byte finishes, the next word stays queued.
    en[0] = 1'b0;
    push(0, 9'h03C); push(0, 9'h1C3);
    tick(3);
    s_pops = pops[0]; s_bytes = bytes[0];
    en[0] = 1'b1;
    c = 0;
    while (bitn[0] != 4 && c < 200) begin tick(1); c++; end
    check("enable_drop_reached_bit", bitn[0], 4);
    en[0] = 1'b0;
    tick(80);
    check("en_drop_pops",  pops[0] - s_pops, 1);
    check("en_drop_bytes", bytes[0] - s_bytes, 1);
    check("en_drop_cs_n",  {31'd0, csn[0]}, 1);
    check("en_drop_busy",  {31'd0, bsy[0]}, 0);
    check("en_drop_queued", wp[0] - rp[0], 1);
    en[0] = 1'b1;
    drain(0, 200);
    check("en_resume_pops",  pops[0] - s_pops, 2);
    check("en_resume_bytes", bytes[0] - s_bytes, 2);

    // Async reset while SCK is high in bit 4.
    s_bytes = bytes[0];
    push(0, 9'h0C3);
    c = 0;
    while (!(bitn[0] == 4 && sck[0]) && c < 200) begin tick(1); c++; end
    check("reset_reached_bit4", {31'd0, sck[0]}, 1);
    rst = 1'b0;
    #1;
    check("async_cs_n", {31'd0, csn[0]}, 1);
    check("async_sck",  {31'd0, sck[0]}, 0);
    check("async_mosi", {31'd0, mosi[0]}, 0);
    check("async_dc",   {31'd0, dcs[0]}, 0);
    check("async_busy", {31'd0, bsy[0]}, 0);
    xp[0]++;  // popped word is lost
    tick(2);
    rst = 1'b1;
    push(0, 9'h05A);
    drain(0, 200);
    check("after_reset_bytes", bytes[0] - s_bytes, 1);

    // Random bursts.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      s_busy = busy_cyc[0]; s_bytes = bytes[0]; s_cs = cs_rises[0];
      for (int k = 0; k < n; k++) push(0, 9'($urandom_range(0, 511)));
      drain(0, 200 * n);
      check("rand_cycles", busy_cyc[0] - s_busy, 34 * n);
      check("rand_bytes",  bytes[0] - s_bytes, n);
      check("rand_cs_rise", cs_rises[0] - s_cs, 1);
    end

    check("all_sent_lane0", xp[0], wp[0]);
    check("all_sent_lane1", xp[1], wp[1]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
